pingpong_loader: RTL and testbench

- Upstream write-side controller for the ping-pong tile buffer.
- Accepts a valid/ready word stream from the DMA and writes each tile into the buffer's write bank at sequential addresses.
- Pulses the buffer's bank-switch input only when the read bank is free, then raises tile_ready for the compute stage.
- Repeats for a programmed number of tiles per job.

---
 rtl/pingpong_pkg.sv | 18 +
 rtl/pingpong_loader_sat_counter.sv | 38 +++
 rtl/pingpong_loader.sv | 189 ++++++++++++++++++
 tb/tb_pingpong_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_pkg.sv
// Shared definitions for the ping-pong tile buffer and its write-side loader.
// Holds the loader FSM state type, the default buffer geometry and the
// performance counter width.
package pingpong_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    WAIT_SWAP = 2'd2,
    SWAP      = 2'd3
  } state_e;

  localparam int DATA_W_DEF = 128;
  localparam int ADDR_W_DEF = 10;
  localparam int DEPTH_DEF  = 1024;
  localparam int PERF_W     = 32;

endpackage

// File: rtl/pingpong_loader_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_ONE = W'(1);
  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q, cnt_d;

  // next count: clear has priority, increment stops at the maximum
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pingpong_loader.sv
// Write-side controller for the ping-pong tile buffer.
// Streams tiles from the DMA into the buffer write bank, swaps banks once the
// read bank is free and flags tile_ready to the compute stage.
// Optional stall/starve performance counters: define PINGPONG_LOADER_PERF_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no job; waiting for start, config checked here
// FILL      | accepting stream words, one buffer write per handshake
// WAIT_SWAP | tile complete; waiting for the read bank to be released
// SWAP      | one-cycle bank-switch pulse, then next tile or done
module pingpong_loader
  import pingpong_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TILES_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [ADDR_W:0]     tile_len_i,
  input  logic [TILES_W-1:0]  num_tiles_i,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic                wr_en_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic                switch_banks_o,
  output logic                tile_ready_o,
  input  logic                cons_done_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_cfg_o,
  output logic [PERF_W-1:0]   stall_cycles_o,
  output logic [PERF_W-1:0]   starve_cycles_o
);

  localparam logic [ADDR_W:0]    PTR_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]    DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [TILES_W-1:0] TILES_ONE = TILES_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     ptr_q, ptr_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [TILES_W-1:0]  tiles_q, tiles_d;
  logic                tile_ready_q, tile_ready_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic cfg_ok;
  logic accept;
  logic hs;
  logic last_word;
  logic last_tile;
  logic swap_go;

  assign cfg_ok    = (tile_len_i != '0) && (tile_len_i <= DEPTH_L) && (num_tiles_i != '0);
  assign accept    = (state_q == IDLE) && start_i && cfg_ok;
  assign hs        = s_valid_i && s_ready_o;
  assign last_word = (ptr_q == (len_q - PTR_ONE));
  assign last_tile = (tiles_q == TILES_ONE);
  // a consumer release in the same cycle frees the read bank just as well
  assign swap_go   = !tile_ready_q || cons_done_i;

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = FILL;
      FILL:      if (hs && last_word) state_d = WAIT_SWAP;
      WAIT_SWAP: if (swap_go) state_d = SWAP;
      SWAP:      state_d = last_tile ? IDLE : FILL;
      default:   state_d = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    s_ready_o      = (state_q == FILL);
    switch_banks_o = (state_q == SWAP);
    busy_o         = (state_q != IDLE);
  end

  // datapath next values: config latch, write pointer, tile count, status
  always_comb begin
    ptr_d        = ptr_q;
    len_d        = len_q;
    tiles_d      = tiles_q;
    wr_en_d      = hs;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_d       = (state_q == SWAP) && last_tile;
    err_d        = (state_q == IDLE) && start_i && !cfg_ok;
    tile_ready_d = tile_ready_q;

    if (accept) begin
      len_d   = tile_len_i;
      tiles_d = num_tiles_i;
      ptr_d   = '0;
    end

    if (hs) begin
      wr_addr_d = ptr_q[ADDR_W-1:0];
      wr_data_d = s_data_i;
      ptr_d     = ptr_q + PTR_ONE;
    end

    if (state_q == SWAP) begin
      tiles_d = tiles_q - TILES_ONE;
      ptr_d   = '0;
    end

    // a new tile landing in the read bank outranks a release of the old one
    if (state_q == SWAP) begin
      tile_ready_d = 1'b1;
    end else if (cons_done_i) begin
      tile_ready_d = 1'b0;
    end
  end

  // datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q        <= '0;
      len_q        <= '0;
      tiles_q      <= '0;
      tile_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      len_q        <= len_d;
      tiles_q      <= tiles_d;
      tile_ready_q <= tile_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign tile_ready_o = tile_ready_q;
  assign done_o       = done_q;
  assign err_cfg_o    = err_q;

`ifdef PINGPONG_LOADER_PERF_EN
  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (accept),
    .inc_i (state_q == WAIT_SWAP),
    .cnt_o (stall_cycles_o)
  );

  sat_counter #(.W(PERF_W)) u_starve_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (accept),
    .inc_i ((state_q == FILL) && !s_valid_i),
    .cnt_o (starve_cycles_o)
  );
`else
  assign stall_cycles_o  = '0;
  assign starve_cycles_o = '0;
`endif

endmodule

// File: tb/tb_pingpong_loader.sv
// Self-checking bench for pingpong_loader: a job-level reference model with a
// two-bank buffer image, a table of start configurations, directed corner
// sequences and randomized jobs.
module tb_pingpong_loader;

  localparam int DATA_W  = 128;
  localparam int ADDR_W  = 10;
  localparam int DEPTH   = 1024;
  localparam int TILES_W = 16;

  logic                clk       = 1'b0;
  logic                rst       = 1'b1;
  logic                start     = 1'b0;
  logic [ADDR_W:0]     tile_len  = '0;
  logic [TILES_W-1:0]  num_tiles = '0;
  logic [DATA_W-1:0]   s_data    = '0;
  logic                s_valid   = 1'b0;
  logic                cons_done = 1'b0;
  logic                s_ready, wr_en, switch_banks, tile_ready, busy, done, err_cfg;
  logic [DATA_W-1:0]   wr_data;
  logic [ADDR_W-1:0]   wr_addr;
  logic [31:0]         stall_cycles, starve_cycles;

  pingpong_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TILES_W(TILES_W)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .tile_len_i      (tile_len),
    .num_tiles_i     (num_tiles),
    .s_data_i        (s_data),
    .s_valid_i       (s_valid),
    .s_ready_o       (s_ready),
    .wr_data_o       (wr_data),
    .wr_en_o         (wr_en),
    .wr_addr_o       (wr_addr),
    .switch_banks_o  (switch_banks),
    .tile_ready_o    (tile_ready),
    .cons_done_i     (cons_done),
    .busy_o          (busy),
    .done_o          (done),
    .err_cfg_o       (err_cfg),
    .stall_cycles_o  (stall_cycles),
    .starve_cycles_o (starve_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // job-level reference model
  bit          m_active, m_pending, m_swap_next, m_done_next, m_err_next, m_prev_hs, m_tr;
  int          m_len, m_tiles_left, m_wcnt, m_prev_addr, m_wbank;
  logic [DATA_W-1:0] m_prev_data;
  longint      m_stall, m_starve;
  logic [DATA_W-1:0] tile_q[$];
  logic [DATA_W-1:0] bank [2][DEPTH];
  int          n_writes = 0, n_switch = 0, n_done = 0, last_addr = 0;

  typedef struct {
    int len;
    int num;
    bit exp_err;
    bit exp_busy;
  } cfg_vec_t;

  cfg_vec_t tbl[7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    m_active = 0; m_pending = 0; m_swap_next = 0; m_done_next = 0; m_err_next = 0;
    m_prev_hs = 0; m_tr = 0; m_len = 0; m_tiles_left = 0; m_wcnt = 0; m_prev_addr = 0;
    m_wbank = 0; m_prev_data = '0; m_stall = 0; m_starve = 0;
    tile_q.delete();
  endtask

  // per-cycle observation at the falling edge: compare, then advance the model
  task automatic mon_step();
    bit e_sr, e_sw, hs, was_active, nsw;
    if (rst) begin
      chk("rst_s_ready", s_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_switch", switch_banks, 0);
      chk("rst_tile_ready", tile_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err_cfg", err_cfg, 0);
      chk("rst_stall", stall_cycles, 0);
      chk("rst_starve", starve_cycles, 0);
      model_reset();
      return;
    end
    e_sw = m_swap_next;
    e_sr = m_active && !m_pending && !e_sw;
    chk("s_ready", s_ready, e_sr);
    chk("switch_banks", switch_banks, e_sw);
    chk("busy", busy, m_active);
    chk("done", done, m_done_next);
    chk("err_cfg", err_cfg, m_err_next);
    chk("tile_ready", tile_ready, m_tr);
    chk("wr_en", wr_en, m_prev_hs);
    if (m_prev_hs) begin
      chk("wr_addr", wr_addr, m_prev_addr);
      chk("wr_data", wr_data, m_prev_data);
    end
`ifdef PINGPONG_LOADER_PERF_EN
    chk("stall_cycles", stall_cycles, m_stall);
    chk("starve_cycles", starve_cycles, m_starve);
`else
    chk("stall_cycles", stall_cycles, 0);
    chk("starve_cycles", starve_cycles, 0);
`endif
    if (wr_en) begin
      bank[m_wbank][wr_addr] = wr_data;
      n_writes++;
      last_addr = int'(wr_addr);
    end
    if (switch_banks) n_switch++;
    if (done) n_done++;

    was_active = m_active;
    hs = e_sr && s_valid;
    nsw = 0;
    if (e_sw) begin
      for (int i = 0; i < tile_q.size(); i++)
        chk("readback", bank[m_wbank][i], tile_q[i]);
      tile_q.delete();
      m_wbank = 1 - m_wbank;
      m_pending = 0;
      m_tiles_left--;
      if (m_tiles_left == 0) m_active = 0;
    end
    m_done_next = e_sw && (m_tiles_left == 0);
    if (m_pending) begin
      m_stall++;
      nsw = !m_tr || cons_done;
    end
    if (e_sr && !s_valid) m_starve++;
    if (hs) begin
      tile_q.push_back(s_data);
      m_prev_addr = m_wcnt;
      m_wcnt++;
      if (m_wcnt == m_len) begin
        m_pending = 1;
        m_wcnt = 0;
      end
    end
    m_prev_hs = hs;
    m_prev_data = s_data;
    m_tr = e_sw ? 1'b1 : (cons_done ? 1'b0 : m_tr);
    m_swap_next = nsw;
    m_err_next = 0;
    if (!was_active && start) begin
      if (tile_len >= 1 && tile_len <= DEPTH && num_tiles != 0) begin
        m_active = 1;
        m_len = int'(tile_len);
        m_tiles_left = int'(num_tiles);
        m_wcnt = 0;
        m_pending = 0;
        m_stall = 0;
        m_starve = 0;
      end else begin
        m_err_next = 1;
      end
    end
  endtask

  // one clock: observe at the falling edge, return 1ns after the rising edge
  task automatic tick();
    @(negedge clk);
    mon_step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len, input int num);
    start = 1'b1;
    tile_len = (ADDR_W+1)'(len);
    num_tiles = TILES_W'(num);
    tick();
    start = 1'b0;
  endtask

  // vmode: 0 always valid, 1 random, 2 pattern 1,0,0; cmode: 0 quiet, 1 random releases and stray starts
  task automatic run_job(input int vmode, input int cmode, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      case (vmode)
        0:       s_valid = 1'b1;
        1:       s_valid = 1'($urandom_range(0, 1));
        default: s_valid = ((n % 3) == 0);
      endcase
      s_data = rnd128();
      cons_done = (cmode == 1) ? ($urandom_range(0, 5) == 0) : 1'b0;
      if (cmode == 1) begin
        start = ($urandom_range(0, 15) == 0);
        tile_len = (ADDR_W+1)'($urandom_range(0, 40));
        num_tiles = TILES_W'($urandom_range(0, 3));
      end
      tick();
      n++;
    end
    s_valid = 1'b0;
    cons_done = 1'b0;
    start = 1'b0;
    chk("job_timeout", busy, 0);
    chk("done_pulse", done, 1);
  endtask

  task automatic clear_tr();
    if (tile_ready) begin
      cons_done = 1'b1;
      tick();
      cons_done = 1'b0;
    end
  endtask

  initial begin
    int w0, s0;
    model_reset();
    tbl = '{'{0, 1, 1, 0}, '{1025, 1, 1, 0}, '{4, 0, 1, 0}, '{2047, 2, 1, 0},
            '{1, 1, 0, 1}, '{3, 2, 0, 1}, '{1024, 0, 1, 0}};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // configuration table
    for (int i = 0; i < 7; i++) begin
      start_job(tbl[i].len, tbl[i].num);
      chk("cfg_err", err_cfg, tbl[i].exp_err);
      chk("cfg_busy", busy, tbl[i].exp_busy);
      if (tbl[i].exp_busy) run_job(1, 1, 2000);
      tick();
      chk("cfg_err_clears", err_cfg, 0);
    end

    // basic fill
    clear_tr();
    w0 = n_writes; s0 = n_switch;
    start_job(4, 1);
    run_job(0, 0, 100);
    chk("basic_writes", n_writes - w0, 4);
    chk("basic_switch", n_switch - s0, 1);
    chk("basic_last_addr", last_addr, 3);
    chk("basic_tile_ready", tile_ready, 1);

    // backpressure on the second and third tiles
    clear_tr();
    s0 = n_switch;
    start_job(8, 3);
    s_valid = 1'b1;
    repeat (25) begin s_data = rnd128(); tick(); end
    s_valid = 1'b0;
    chk("bp_s_ready", s_ready, 0);
    chk("bp_busy", busy, 1);
    chk("bp_tile_ready", tile_ready, 1);
    chk("bp_one_switch", n_switch - s0, 1);
    cons_done = 1'b1;
    tick();
    cons_done = 1'b0;
    chk("bp_switch_after_release", switch_banks, 1);
    s_valid = 1'b1;
    repeat (15) begin s_data = rnd128(); tick(); end
    s_valid = 1'b0;
    chk("bp_stall_again", s_ready, 0);
    chk("bp_two_switch", n_switch - s0, 2);
    cons_done = 1'b1;
    tick();
    cons_done = 1'b0;
    run_job(0, 0, 100);
    chk("bp_three_switch", n_switch - s0, 3);

    // release arriving in the swap cycle itself: tile_ready must end set
    start_job(2, 1);
    s_valid = 1'b1;
    repeat (6) begin s_data = rnd128(); tick(); end
    s_valid = 1'b0;
    cons_done = 1'b1;
    tick();
    chk("sim_swap", switch_banks, 1);
    tick();
    cons_done = 1'b0;
    chk("sim_tile_ready", tile_ready, 1);
    chk("sim_done", done, 1);

    // full-depth tile
    clear_tr();
    w0 = n_writes;
    start_job(1024, 1);
    run_job(0, 0, 1200);
    chk("depth_writes", n_writes - w0, 1024);
    chk("depth_last_addr", last_addr, 1023);

    // starvation gaps
    clear_tr();
    w0 = n_writes;
    start_job(5, 1);
    run_job(2, 0, 200);
    chk("starve_writes", n_writes - w0, 5);
`ifdef PINGPONG_LOADER_PERF_EN
    chk("starve_count", starve_cycles, 8);
`else
    chk("starve_count", starve_cycles, 0);
`endif

    // reset in the middle of a tile
    clear_tr();
    s0 = n_switch;
    start_job(6, 1);
    s_valid = 1'b1;
    repeat (3) begin s_data = rnd128(); tick(); end
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_tile_ready", tile_ready, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_no_switch", n_switch - s0, 0);
    w0 = n_writes;
    start_job(6, 1);
    run_job(0, 0, 100);
    chk("post_rst_writes", n_writes - w0, 6);
    chk("post_rst_switch", n_switch - s0, 1);

    // randomized jobs
    for (int j = 0; j < 30; j++) begin
      int len, num;
      bit legal;
      len = $urandom_range(0, 30);
      num = $urandom_range(0, 4);
      legal = (len >= 1) && (num >= 1);
      start_job(len, num);
      chk("rand_err", err_cfg, !legal);
      if (legal) run_job(1, 1, 4000);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
